can_tx_mailbox_arbiter: RTL and testbench
=========================================

// Module: can_tx_mailbox_arbiter
// PURPOSE
//   Shares the single CAN frame transmitter between NUM_MB transmit mailboxes. Host loads frames
//   into mailboxes; block picks the pending frame with lowest 11-bit ID (CAN priority, tie -> lowest
//   index), drives it to the transmitter via TX_REQ/TX_BUSY/TX_COMPLETE, reports per-mailbox done.
//   Sits between host register interface and transmitter; owns all transmitter request sequencing.
// PARAMETERS
//   NUM_MB       4      number of mailboxes (2..8)
//   TIMEOUT_CYC  256    max cycles in WAIT_BUSY or WAIT_DONE before abandoning frame (>=160)
// PORTS
//   clk          in   1        clock
//   rst          in   1        synchronous, active-high reset
//   wr_en        in   1        load mailbox wr_idx this cycle
//   wr_idx       in   $clog2(NUM_MB)  target mailbox
//   wr_id        in   11       frame ID
//   wr_dlc       in   4        data length code
//   wr_data      in   8x8      payload bytes, [0] sent first
//   abort        in   NUM_MB   per-mailbox cancel request (level, sampled each cycle)
//   pending      out  NUM_MB   mailbox holds frame awaiting/under transmission
//   done         out  NUM_MB   one-cycle pulse: mailbox frame transmitted
//   wr_err       out  1        one-cycle pulse: write rejected (target in flight)
//   err_timeout  out  1        one-cycle pulse: in-flight frame abandoned on timeout
//   inflight     out  1        a frame is owned by transmitter
//   cur_idx      out  $clog2(NUM_MB)  mailbox in flight (valid while inflight)
//   TX_REQ       out  1        request to transmitter
//   TX_ID/TX_DLC/TX_DATA out 11/4/8x8  frame to transmitter
//   TX_BUSY      in   1        transmitter busy
//   TX_COMPLETE  in   1        transmitter frame finished
// BEHAVIOUR
//   Reset: pending=0, done=0, wr_err=0, err_timeout=0, inflight=0, cur_idx=0, TX_REQ=0,
//     TX_ID/TX_DLC/TX_DATA=0, state=IDLE, timeout counter=0; mailbox storage cleared to 0.
//   Reset mid-frame: TX_REQ drops next edge, all pending cleared, no done/err pulse.
//   Write: wr_en to mailbox not in flight stores id, min(wr_dlc,8), data; sets pending next cycle;
//     overwrite of pending-not-inflight mailbox allowed (new content replaces old, no pulse).
//     wr_en to in-flight mailbox: ignored, wr_err pulses 1 cycle.
//   Abort: abort[i] on pending, not-in-flight mailbox clears pending[i] next cycle, no done.
//     Abort on in-flight mailbox ignored (frame cannot be withdrawn mid-transmission).
//     wr_en and abort same mailbox same cycle: write wins.
//   FSM:
//     IDLE: if |pending and TX_BUSY=0 and TX_COMPLETE=0 -> ARB.
//     ARB (1 cycle): register winner = lowest ID among pending not aborted this cycle,
//       tie -> lowest index; latch its frame onto TX_*; set inflight, cur_idx -> REQ.
//       If no candidate remains (all aborted) -> IDLE.
//     REQ: TX_REQ=1; stays until TX_BUSY=1 -> WAIT_DONE, TX_REQ=0 same edge.
//     WAIT_DONE: on TX_COMPLETE=1 -> done[cur_idx] pulse, pending[cur_idx] clear -> RELEASE.
//     RELEASE: TX_REQ=0; wait TX_BUSY=0 and TX_COMPLETE=0 -> IDLE, inflight=0.
//   Arbitration is non-preemptive: lower-ID write during REQ/WAIT_DONE waits for next ARB.
//   Latency: write to TX_REQ rising, idle system = 3 edges (pending, ARB, REQ).
//   TX_ID/TX_DLC/TX_DATA held constant from ARB exit until return to IDLE.
//   Timeout: counter clears on entering REQ and WAIT_DONE, increments in each; reaching
//     TIMEOUT_CYC -> err_timeout pulse, pending[cur_idx] kept (retried at next ARB),
//     TX_REQ=0 -> RELEASE. Counter saturates; never wraps.
//   done and err_timeout never pulse same cycle; done has priority if TX_COMPLETE at timeout.
// TESTING
//   Single frame: load mb0 id=0x123 dlc=2 data=AA,55 -> TX_REQ at +3 edges, TX_ID=0x123,
//     done[0] after TX_COMPLETE, pending[0]=0.
//   Priority: load mb0 id=0x200, mb1 id=0x100, mb2 id=0x100 same idle window -> order mb1, mb2, mb0.
//   Write/abort collisions: wr_en to cur_idx while in flight -> wr_err=1 one cycle, frame unchanged;
//     abort mb2 pending -> pending[2]=0, no done[2].
//   DLC clamp: wr_dlc=15 -> TX_DLC=8.
//   Timeout: hold TX_BUSY=0 forever -> err_timeout after TIMEOUT_CYC cycles, pending kept, retried.
//   Reset mid-frame in WAIT_DONE -> TX_REQ=0, pending=0, inflight=0 next edge, no done pulse.

Source files
------------

// File: rtl/can_tx_mailbox_arbiter.sv
// Shares one CAN frame transmitter among NUM_MB host-loaded transmit mailboxes.
// Lowest pending ID wins (tie -> lowest index); arbitration is non-preemptive.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | nothing in flight; waits for a pending frame and a quiet transmitter
// ARB       | one cycle: pick winner, latch its frame onto TX_*, mark inflight
// REQ       | TX_REQ high until the transmitter reports busy
// WAIT_DONE | transmitter owns the frame; wait for TX_COMPLETE
// RELEASE   | wait for transmitter to go quiet before returning to IDLE
module can_tx_mailbox_arbiter #(
  parameter int NUM_MB      = 4,
  parameter int TIMEOUT_CYC = 256,
  localparam int IW         = $clog2(NUM_MB)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_idx,
  input  logic [10:0]          wr_id,
  input  logic [3:0]           wr_dlc,
  input  logic [7:0][7:0]      wr_data,
  input  logic [NUM_MB-1:0]    abort,
  output logic [NUM_MB-1:0]    pending,
  output logic [NUM_MB-1:0]    done,
  output logic                 wr_err,
  output logic                 err_timeout,
  output logic                 inflight,
  output logic [IW-1:0]        cur_idx,
  output logic                 TX_REQ,
  output logic [10:0]          TX_ID,
  output logic [3:0]           TX_DLC,
  output logic [7:0][7:0]      TX_DATA,
  input  logic                 TX_BUSY,
  input  logic                 TX_COMPLETE
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REQ,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  state_t state, state_nxt;

  logic [10:0]     mb_id   [NUM_MB];
  logic [3:0]      mb_dlc  [NUM_MB];
  logic [7:0][7:0] mb_data [NUM_MB];

  logic [10:0]     eff_id   [NUM_MB];
  logic [3:0]      eff_dlc  [NUM_MB];
  logic [7:0][7:0] eff_data [NUM_MB];

  logic [CW-1:0]     cnt;
  logic              cnt_at_limit;
  logic              timeout_hit;
  logic              complete_hit;
  logic              wr_hit_inflight;
  logic              wr_ok;
  logic [NUM_MB-1:0] wr_mask;
  logic [NUM_MB-1:0] cand;
  logic [3:0]        wr_dlc_clamp;

  logic              found;
  logic [IW-1:0]     win_idx;
  logic [10:0]       win_id;
  logic [3:0]        win_dlc;
  logic [7:0][7:0]   win_data;

  assign wr_hit_inflight = wr_en && inflight && (wr_idx == cur_idx);
  assign wr_ok           = wr_en && !wr_hit_inflight;
  assign wr_dlc_clamp    = (wr_dlc > 4'd8) ? 4'd8 : wr_dlc;
  assign cnt_at_limit    = (cnt >= CW'(TIMEOUT_CYC - 1));
  assign TX_REQ          = (state == S_REQ);

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (wr_ok && (wr_idx == IW'(i))) wr_mask[i] = 1'b1;
    end
  end

  // A write landing in the ARB cycle is forwarded so the latched frame matches storage.
  always_comb begin
    for (int i = 0; i < NUM_MB; i++) begin
      eff_id[i]   = wr_mask[i] ? wr_id        : mb_id[i];
      eff_dlc[i]  = wr_mask[i] ? wr_dlc_clamp : mb_dlc[i];
      eff_data[i] = wr_mask[i] ? wr_data      : mb_data[i];
    end
  end

  always_comb begin
    cand     = pending & ~(abort & ~wr_mask);
    found    = 1'b0;
    win_idx  = '0;
    win_id   = '0;
    win_dlc  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (cand[i] && (!found || (eff_id[i] < win_id))) begin
        found    = 1'b1;
        win_idx  = IW'(i);
        win_id   = eff_id[i];
        win_dlc  = eff_dlc[i];
        win_data = eff_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    timeout_hit  = 1'b0;
    complete_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if ((|pending) && !TX_BUSY && !TX_COMPLETE) state_nxt = S_ARB;
      end
      S_ARB: begin
        state_nxt = found ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        if (TX_BUSY) begin
          state_nxt = S_WAIT_DONE;
        end else if (cnt_at_limit) begin
          timeout_hit = 1'b1;
          state_nxt   = S_RELEASE;
        end
      end
      S_WAIT_DONE: begin
        if (TX_COMPLETE) begin
          complete_hit = 1'b1;
          state_nxt    = S_RELEASE;
        end else if (cnt_at_limit) begin
          timeout_hit = 1'b1;
          state_nxt   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!TX_BUSY && !TX_COMPLETE) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Saturating timeout counter, restarted whenever REQ or WAIT_DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_nxt != state) &&
                 ((state_nxt == S_REQ) || (state_nxt == S_WAIT_DONE))) begin
      cnt <= '0;
    end else if (((state == S_REQ) || (state == S_WAIT_DONE)) &&
                 (cnt != CW'(TIMEOUT_CYC))) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      done        <= '0;
      wr_err      <= 1'b0;
      err_timeout <= 1'b0;
      inflight    <= 1'b0;
      cur_idx     <= '0;
      TX_ID       <= '0;
      TX_DLC      <= '0;
      TX_DATA     <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        mb_id[i]   <= '0;
        mb_dlc[i]  <= '0;
        mb_data[i] <= '0;
      end
    end else begin
      done        <= '0;
      wr_err      <= wr_hit_inflight;
      err_timeout <= timeout_hit;

      for (int i = 0; i < NUM_MB; i++) begin
        if (wr_mask[i]) begin
          mb_id[i]   <= wr_id;
          mb_dlc[i]  <= wr_dlc_clamp;
          mb_data[i] <= wr_data;
          pending[i] <= 1'b1;
        end else if (abort[i] && !(inflight && (cur_idx == IW'(i)))) begin
          pending[i] <= 1'b0;
        end else if (complete_hit && (cur_idx == IW'(i))) begin
          pending[i] <= 1'b0;
        end
      end

      if (complete_hit) done[cur_idx] <= 1'b1;

      if ((state == S_ARB) && found) begin
        inflight <= 1'b1;
        cur_idx  <= win_idx;
        TX_ID    <= win_id;
        TX_DLC   <= win_dlc;
        TX_DATA  <= win_data;
      end else if ((state == S_RELEASE) && (state_nxt == S_IDLE)) begin
        inflight <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// Directed bench for can_tx_mailbox_arbiter: latency, priority order, write/abort
// collisions, DLC clamp, timeout with retry, and reset mid-frame.
module tb_can_tx_mailbox_arbiter;

  localparam int NUM_MB      = 4;
  localparam int TIMEOUT_CYC = 256;
  localparam int IW          = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic [IW-1:0]        wr_idx;
  logic [10:0]          wr_id;
  logic [3:0]           wr_dlc;
  logic [7:0][7:0]      wr_data;
  logic [NUM_MB-1:0]    abort;
  logic [NUM_MB-1:0]    pending;
  logic [NUM_MB-1:0]    done;
  logic                 wr_err;
  logic                 err_timeout;
  logic                 inflight;
  logic [IW-1:0]        cur_idx;
  logic                 TX_REQ;
  logic [10:0]          TX_ID;
  logic [3:0]           TX_DLC;
  logic [7:0][7:0]      TX_DATA;
  logic                 TX_BUSY;
  logic                 TX_COMPLETE;

  int checks = 0;
  int errors = 0;
  bit to_seen;

  always #5 clk = ~clk;

  can_tx_mailbox_arbiter #(.NUM_MB(NUM_MB), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_id(wr_id),
    .wr_dlc(wr_dlc), .wr_data(wr_data), .abort(abort), .pending(pending),
    .done(done), .wr_err(wr_err), .err_timeout(err_timeout), .inflight(inflight),
    .cur_idx(cur_idx), .TX_REQ(TX_REQ), .TX_ID(TX_ID), .TX_DLC(TX_DLC),
    .TX_DATA(TX_DATA), .TX_BUSY(TX_BUSY), .TX_COMPLETE(TX_COMPLETE)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [10:0] id, input logic [3:0] dlc,
                    input logic [7:0] b0, input logic [7:0] b1);
    wr_en      = 1'b1;
    wr_idx     = IW'(idx);
    wr_id      = id;
    wr_dlc     = dlc;
    wr_data    = '0;
    wr_data[0] = b0;
    wr_data[1] = b1;
    tick();
    wr_en      = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int n = 0; n < 20 && !TX_REQ; n++) tick();
    chk(tag, 64'(TX_REQ), 64'd1);
  endtask

  task automatic finish_frame(input string tag, input logic [NUM_MB-1:0] exp_done);
    TX_BUSY = 1'b1;
    tick();
    TX_COMPLETE = 1'b1;
    tick();
    chk(tag, 64'(done), 64'(exp_done));
    TX_COMPLETE = 1'b0;
    TX_BUSY     = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_id = '0; wr_dlc = '0; wr_data = '0;
    abort = '0; TX_BUSY = 1'b0; TX_COMPLETE = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_pending",  64'(pending),  64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_txreq",    64'(TX_REQ),   64'd0);
    chk("rst_txid",     64'(TX_ID),    64'd0);
    chk("rst_curidx",   64'(cur_idx),  64'd0);

    // single frame, 3-edge latency
    wr(0, 11'h123, 4'd2, 8'hAA, 8'h55);
    chk("sf_pending", 64'(pending), 64'h1);
    chk("sf_req_e1",  64'(TX_REQ),  64'd0);
    tick();
    chk("sf_req_e2",  64'(TX_REQ),  64'd0);
    tick();
    chk("sf_req_e3",  64'(TX_REQ),  64'd1);
    chk("sf_id",      64'(TX_ID),   64'h123);
    chk("sf_dlc",     64'(TX_DLC),  64'd2);
    chk("sf_data",    64'(TX_DATA), 64'h55AA);
    chk("sf_inflight",64'(inflight),64'd1);
    TX_BUSY = 1'b1;
    tick();
    chk("sf_req_drop", 64'(TX_REQ), 64'd0);
    TX_COMPLETE = 1'b1;
    tick();
    chk("sf_done",     64'(done),    64'h1);
    chk("sf_pend_clr", 64'(pending), 64'h0);
    TX_COMPLETE = 1'b0;
    TX_BUSY     = 1'b0;
    tick();
    chk("sf_done_pulse", 64'(done),     64'h0);
    chk("sf_idle",       64'(inflight), 64'd0);

    // priority: mb1 (0x100), mb2 (0x100), mb0 (0x200)
    TX_BUSY = 1'b1;
    wr(0, 11'h200, 4'd1, 8'h01, 8'h00);
    wr(1, 11'h100, 4'd1, 8'h02, 8'h00);
    wr(2, 11'h100, 4'd1, 8'h03, 8'h00);
    chk("pr_pending", 64'(pending), 64'h7);
    TX_BUSY = 1'b0;
    wait_req("pr_req1");
    chk("pr_idx1", 64'(cur_idx), 64'd1);
    chk("pr_id1",  64'(TX_ID),   64'h100);
    finish_frame("pr_done1", 4'b0010);
    wait_req("pr_req2");
    chk("pr_idx2", 64'(cur_idx), 64'd2);
    chk("pr_id2",  64'(TX_ID),   64'h100);
    finish_frame("pr_done2", 4'b0100);
    wait_req("pr_req3");
    chk("pr_idx3", 64'(cur_idx), 64'd0);
    chk("pr_id3",  64'(TX_ID),   64'h200);
    finish_frame("pr_done3", 4'b0001);

    // write/abort collisions
    TX_BUSY = 1'b1;
    wr(3, 11'h050, 4'd1, 8'h11, 8'h00);
    wr(2, 11'h300, 4'd1, 8'h22, 8'h00);
    TX_BUSY = 1'b0;
    wait_req("col_req");
    chk("col_idx", 64'(cur_idx), 64'd3);
    wr(3, 11'h7FF, 4'd4, 8'hFF, 8'hFF);
    chk("col_wr_err",  64'(wr_err), 64'd1);
    chk("col_id_kept", 64'(TX_ID),  64'h050);
    tick();
    chk("col_wr_err_pulse", 64'(wr_err), 64'd0);
    abort = 4'b0100;
    tick();
    abort = '0;
    chk("col_abort_mb2", 64'(pending), 64'h8);
    abort = 4'b1000;
    tick();
    abort = '0;
    chk("col_abort_inflight", 64'(pending), 64'h8);
    finish_frame("col_done", 4'b1000);
    for (int n = 0; n < 5; n++) tick();
    chk("col_no_retx",   64'(TX_REQ),  64'd0);
    chk("col_pend_none", 64'(pending), 64'h0);

    // DLC clamp
    wr(1, 11'h010, 4'd15, 8'h01, 8'h02);
    wait_req("dlc_req");
    chk("dlc_clamp", 64'(TX_DLC), 64'd8);
    finish_frame("dlc_done", 4'b0010);

    // timeout in REQ, then retry
    wr(0, 11'h321, 4'd3, 8'h33, 8'h44);
    wait_req("to_req");
    to_seen = 1'b0;
    for (int n = 0; n < TIMEOUT_CYC - 1; n++) begin
      tick();
      if (err_timeout) to_seen = 1'b1;
    end
    chk("to_early",    64'(to_seen), 64'd0);
    chk("to_req_held", 64'(TX_REQ),  64'd1);
    tick();
    chk("to_pulse",    64'(err_timeout), 64'd1);
    chk("to_req_drop", 64'(TX_REQ),      64'd0);
    chk("to_pend_kept",64'(pending),     64'h1);
    chk("to_no_done",  64'(done),        64'h0);
    tick();
    chk("to_pulse_end", 64'(err_timeout), 64'd0);
    wait_req("to_retry");
    chk("to_retry_id", 64'(TX_ID), 64'h321);

    // reset mid-frame in WAIT_DONE
    TX_BUSY = 1'b1;
    tick();
    chk("rm_in_wait", 64'(TX_REQ), 64'd0);
    rst = 1'b1;
    TX_COMPLETE = 1'b1;
    tick();
    rst = 1'b0;
    TX_COMPLETE = 1'b0;
    TX_BUSY = 1'b0;
    chk("rm_pending",  64'(pending),  64'h0);
    chk("rm_inflight", 64'(inflight), 64'd0);
    chk("rm_no_done",  64'(done),     64'h0);
    chk("rm_txid",     64'(TX_ID),    64'h0);
    tick();
    chk("rm_txreq",    64'(TX_REQ),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
